// File: rtl/tdc_hw_sampler.sv
// Sequencer that toggles the TDC launch input once per sample and reads back
// the Hamming-weight stream, reporting sum, mean, min and max per run.
module tdc_hw_sampler #(
    parameter int HW_W    = 7,
    parameter int LOG2_N  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [HW_W-1:0]          i_hw_in,
    input  logic                     i_val_in,
    output logic                     o_pg_tog_out,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_timeout_err,
    output logic [LOG2_N:0]          o_sample_cnt,
    output logic [HW_W+LOG2_N-1:0]   o_sum_out,
    output logic [HW_W-1:0]          o_mean_out,
    output logic [HW_W-1:0]          o_min_out,
    output logic [HW_W-1:0]          o_max_out
);

    localparam int ACC_W = HW_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] N_SAMPLES   = CNT_W'(2 ** LOG2_N);
    localparam logic [7:0]       TIMEOUT_VAL = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [HW_W-1:0]    r_mn;
    logic [HW_W-1:0]    r_mx;
    logic [HW_W-1:0]    r_sample;
    logic [7:0]         r_timer;
    logic               r_pg_tog;
    logic               r_timeout_err;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [ACC_W-1:0]   r_sum;
    logic [HW_W-1:0]    r_mean;
    logic [HW_W-1:0]    r_min;
    logic [HW_W-1:0]    r_max;

    logic [ACC_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [HW_W-1:0]    w_mn_next;
    logic [HW_W-1:0]    w_mx_next;
    logic               w_timer_expired;

    assign w_acc_next      = r_acc + ACC_W'(r_sample);
    assign w_cnt_next      = r_cnt + CNT_W'(1);
    assign w_mn_next       = (r_sample < r_mn) ? r_sample : r_mn;
    assign w_mx_next       = (r_sample > r_mx) ? r_sample : r_mx;
    assign w_timer_expired = (r_timer == TIMEOUT_VAL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_next = S_LAUNCH;
            S_LAUNCH: w_state_next = S_WAIT;
            // A strobe in the expiry cycle still wins over the timeout.
            S_WAIT: begin
                if (i_val_in)             w_state_next = S_ACCUM;
                else if (w_timer_expired) w_state_next = S_DONE;
            end
            S_ACCUM:  w_state_next = (w_cnt_next == N_SAMPLES) ? S_DONE : S_LAUNCH;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_mn          <= '1;
            r_mx          <= '0;
            r_sample      <= '0;
            r_timer       <= '0;
            r_pg_tog      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_sample_cnt  <= '0;
            r_sum         <= '0;
            r_mean        <= '0;
            r_min         <= '1;
            r_max         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc         <= '0;
                        r_cnt         <= '0;
                        r_mn          <= '1;
                        r_mx          <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    r_pg_tog <= ~r_pg_tog;
                    r_timer  <= '0;
                end
                S_WAIT: begin
                    if (i_val_in) begin
                        r_sample <= i_hw_in;
                    end else if (w_timer_expired) begin
                        // Aborted run publishes whatever was gathered so far.
                        r_timeout_err <= 1'b1;
                        r_sample_cnt  <= r_cnt;
                        r_sum         <= r_acc;
                        r_mean        <= r_acc[ACC_W-1:LOG2_N];
                        r_min         <= r_mn;
                        r_max         <= r_mx;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_ACCUM: begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_cnt_next;
                    r_mn  <= w_mn_next;
                    r_mx  <= w_mx_next;
                    if (w_cnt_next == N_SAMPLES) begin
                        r_sample_cnt <= w_cnt_next;
                        r_sum        <= w_acc_next;
                        r_mean       <= w_acc_next[ACC_W-1:LOG2_N];
                        r_min        <= w_mn_next;
                        r_max        <= w_mx_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_pg_tog_out  = r_pg_tog;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_timeout_err = r_timeout_err;
    assign o_sample_cnt  = r_sample_cnt;
    assign o_sum_out     = r_sum;
    assign o_mean_out    = r_mean;
    assign o_min_out     = r_min;
    assign o_max_out     = r_max;

endmodule
